// File: rtl/c2_e3_pkg.sv
// c2_e3_pkg: shared types, defaults and the double-dabble digit corrector
package c2_e3_pkg;
  localparam int W_IN_DEF = 11;
  localparam int N_DIG_DEF = 4;
  localparam logic [3:0] E3_BIAS = 4'd3;
  typedef logic [3:0] digit_t;
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;
  function automatic digit_t dd_fix(digit_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/c2_e3_conv_ctrl_dd_step.sv
// dd_step: one double-dabble iteration (add-3 correction then shift {bcd,mag} left)
module dd_step
  import c2_e3_pkg::*;
#(
  parameter int W_IN = W_IN_DEF,
  parameter int N_DIG = N_DIG_DEF
) (
  input  logic [4*N_DIG-1:0] bcd,
  input  logic [W_IN-1:0]    mag,
  output logic [4*N_DIG-1:0] bcd_n,
  output logic [W_IN-1:0]    mag_n
);
  logic [4*N_DIG-1:0] adj;
  for (genvar d = 0; d < N_DIG; d++) begin : g_adj
    assign adj[4*d+:4] = dd_fix(bcd[4*d+:4]);
  end
  assign {bcd_n, mag_n} = {adj, mag} << 1;
endmodule

// File: rtl/c2_e3_conv_ctrl.sv
// c2_e3_conv_ctrl: round-robin shared two's-complement to sign+decimal converter.
// Define EXCESS3_OUT_EN to emit excess-3 digits instead of plain BCD.
module c2_e3_conv_ctrl
  import c2_e3_pkg::*;
#(
  parameter int W_IN = W_IN_DEF,
  parameter int N_DIG = N_DIG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  input  logic [W_IN-1:0]    req_data0,
  input  logic [W_IN-1:0]    req_data1,
  output logic [1:0]         req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic               res_sign,
  output logic [4*N_DIG-1:0] res_digits,
  output logic               busy
);
  localparam int CW = $clog2(W_IN);
  conv_state_t state;
  logic rr_ptr, gnt_id;
  logic [W_IN-1:0] op, mag, mag_n;
  logic [4*N_DIG-1:0] bcd, bcd_n, bcd_out;
  logic [CW-1:0] cnt;
  always_comb begin
    gnt_id = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    req_ready = (state == IDLE && |req_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    op = gnt_id ? req_data1 : req_data0;
  end
  assign busy = state != IDLE;
  dd_step #(.W_IN(W_IN), .N_DIG(N_DIG)) u_step (
    .bcd(bcd), .mag(mag), .bcd_n(bcd_n), .mag_n(mag_n)
  );
  for (genvar d = 0; d < N_DIG; d++) begin : g_out
`ifdef EXCESS3_OUT_EN
    assign bcd_out[4*d+:4] = bcd_n[4*d+:4] + E3_BIAS;
`else
    assign bcd_out[4*d+:4] = bcd_n[4*d+:4];
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= 1'b0;
      res_valid <= 1'b0;
      res_id <= 1'b0;
      res_sign <= 1'b0;
      res_digits <= '0;
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          res_sign <= op[W_IN-1];
          mag <= op[W_IN-1] ? -op : op;
          res_id <= gnt_id;
          rr_ptr <= ~gnt_id;
          bcd <= '0;
          cnt <= '0;
          state <= CONV;
        end
        CONV: begin
          mag <= mag_n;
          bcd <= bcd_n;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W_IN - 1)) begin
            res_digits <= bcd_out;
            res_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2_e3_conv_ctrl.sv
// tb_c2_e3_conv_ctrl: directed and random checks against a div/mod reference model.
// Honors EXCESS3_OUT_EN the same way as the design.
module tb_c2_e3_conv_ctrl;
  import c2_e3_pkg::*;
  localparam int W = W_IN_DEF;
  localparam int N = N_DIG_DEF;
  localparam int DW = 4 * N;
  logic clk = 0, rst_n = 0, res_ready = 1;
  logic [1:0] req_valid = 0, req_ready;
  logic [W-1:0] req_data0 = 0, req_data1 = 0;
  logic res_valid, res_id, res_sign, busy;
  logic [DW-1:0] res_digits;
  int checks = 0, errors = 0, results = 0;
  c2_e3_conv_ctrl #(.W_IN(W), .N_DIG(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_sign(res_sign),
    .res_digits(res_digits), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [DW-1:0] e3(logic [DW-1:0] b);
    logic [DW-1:0] r = b;
`ifdef EXCESS3_OUT_EN
    for (int d = 0; d < N; d++) r[4*d+:4] = b[4*d+:4] + 4'd3;
`endif
    return r;
  endfunction
  function automatic logic [DW-1:0] to_dec(logic [W-1:0] x);
    int v, p;
    logic [DW-1:0] r;
    v = int'($signed(x));
    if (v < 0) v = -v;
    p = 1;
    r = '0;
    for (int d = 0; d < N; d++) begin
      r[4*d+:4] = 4'((v / p) % 10);
      p *= 10;
    end
    return e3(r);
  endfunction
  // Reference model: one outstanding job, a round-robin pointer and edge count since accept
  bit m_busy = 0, m_rr = 0, m_zero = 1, m_id = 0, m_sign = 0, m_g, m_rv;
  int m_age = 0;
  logic [DW-1:0] m_dig = '0;
  logic [1:0] m_rdy;
  logic [W-1:0] m_op;
  always @(negedge clk) begin
    m_g = req_valid[m_rr] ? m_rr : !m_rr;
    m_rdy = (!m_busy && req_valid != 0) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    m_rv = m_busy && m_age >= W;
    chk("req_ready", 32'(req_ready), 32'(m_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    if (m_rv || m_zero) begin
      chk("res_id", 32'(res_id), 32'(m_id));
      chk("res_sign", 32'(res_sign), 32'(m_sign));
      chk("res_digits", 32'(res_digits), 32'(m_dig));
    end
    if (!rst_n) begin
      m_busy = 0; m_rr = 0; m_zero = 1; m_id = 0; m_sign = 0; m_dig = '0;
    end else if (m_busy) begin
      if (m_rv && res_ready) begin
        m_busy = 0;
        results++;
      end else m_age++;
    end else if (m_rdy != 0) begin
      m_op = m_g ? req_data1 : req_data0;
      m_busy = 1; m_age = 0; m_rr = !m_g; m_id = m_g; m_zero = 0;
      m_sign = m_op[W-1];
      m_dig = to_dec(m_op);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; req_valid = 0; res_ready = 1;
    tick(2);
    rst_n = 1;
  endtask
  task automatic wait_res(output int e);
    e = 1;
    @(negedge clk);
    while (!res_valid && e < 40) begin
      @(negedge clk);
      e++;
    end
  endtask
  task automatic conv(input bit k, input logic [W-1:0] d, input bit es, input logic [DW-1:0] ed);
    int t = 0, e;
    if (k) req_data1 = d; else req_data0 = d;
    req_valid[k] = 1;
    @(negedge clk);
    while (!req_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("grant", 32'(req_ready[k]), 1);
    tick();
    req_valid[k] = 0;
    wait_res(e);
    chk("latency", e, W + 1);
    chk("lit_id", 32'(res_id), 32'(k));
    chk("lit_sign", 32'(res_sign), 32'(es));
    chk("lit_digits", 32'(res_digits), 32'(e3(ed)));
    tick();
  endtask
  initial begin
    int e, cyc;
    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_digits", 32'(res_digits), 0);
    tick();
    conv(0, 11'h400, 1, 16'h1024);
    conv(1, 11'h3FF, 0, 16'h1023);
    conv(0, 11'd250, 0, 16'h0250);
    do_reset();
    req_data0 = 11'h7FF; req_data1 = 11'h000; req_valid = 2'b11;
    @(negedge clk);
    chk("sim_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid[0] = 0;
    wait_res(e);
    chk("sim0_id", 32'(res_id), 0);
    chk("sim0_sign", 32'(res_sign), 1);
    chk("sim0_digits", 32'(res_digits), 32'(e3(16'h0001)));
    @(negedge clk);
    chk("sim_second_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 0;
    wait_res(e);
    chk("sim1_id", 32'(res_id), 1);
    chk("sim1_sign", 32'(res_sign), 0);
    chk("sim1_digits", 32'(res_digits), 32'(e3(16'h0000)));
    tick();
    res_ready = 0;
    req_data0 = 11'd5; req_valid = 2'b01;
    tick();
    req_data1 = -11'sd7; req_valid = 2'b10;
    wait_res(e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_digits", 32'(res_digits), 32'(e3(16'h0005)));
    end
    tick();
    res_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("bp_after_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 0;
    wait_res(e);
    chk("bp_id", 32'(res_id), 1);
    chk("bp_sign", 32'(res_sign), 1);
    chk("bp_res_digits", 32'(res_digits), 32'(e3(16'h0007)));
    tick();
    do_reset();
    req_data0 = -11'sd123; req_valid = 2'b01;
    tick();
    req_valid = 0;
    tick(6);
    rst_n = 0;
    tick();
    @(negedge clk);
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_sign", 32'(res_sign), 0);
    chk("mid_rst_digits", 32'(res_digits), 0);
    rst_n = 1;
    tick();
    conv(1, -11'sd1000, 1, 16'h1000);
    e = results + 2000;
    cyc = 0;
    while (results < e && cyc < 60000) begin
      req_valid = 2'($urandom);
      req_data0 = W'($urandom);
      req_data1 = W'($urandom);
      res_ready = ($urandom % 4) != 0;
      tick();
      cyc++;
    end
    chk("random_done", 32'(results >= e), 1);
    req_valid = 0; res_ready = 1;
    tick(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
